gradient_calc: RTL and testbench
================================

# gradient_calc

Upstream stage of the LSD angle path. Consumes a raster-order 8-bit grayscale pixel stream and computes the 2x2 LSD image gradient for every pixel with a full 2x2 neighbourhood. Emits signed 9-bit components in [-255, 255] that feed `arctan_calc` directly (`in_x1` = vertical, `in_x2` = horizontal). Also emits an L1 magnitude for downstream thresholding.

## Interface
- `IMG_WIDTH`, default 640: pixels per line, must be ≥ 2.
- `IMG_HEIGHT`, default 480: lines per frame, must be ≥ 2.
- `clock`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  pixel on `in_pixel` accepted this cycle.
- `in_sof`  in  1  qualified by `in_valid`; this pixel is (0,0) of a new frame.
- `in_pixel`  in  8  unsigned intensity.
- `out_valid`  out  1  gradient outputs valid this cycle.
- `out_x1`  out  9  signed vertical gradient gy.
- `out_x2`  out  9  signed horizontal gradient gx.
- `out_mag`  out  9  unsigned |gx|+|gy| saturated to 511.
- `out_last`  out  1  with `out_valid`: last gradient of the frame.

## Operation
- Internal `col` in 0..IMG_WIDTH-1 and `row` in 0..IMG_HEIGHT-1 give the position of the accepted pixel.
- Each accepted pixel advances `col`. When `col` wraps, `row` advances. When `row` wraps, a new frame begins.
- `in_sof` with `in_valid` forces the accepted pixel to (0,0), regardless of counter state. Counters then continue from (1,0).
- One line buffer, IMG_WIDTH×8, holds the previous row. It is written at `col` with every accepted pixel. Its contents are not reset.
- For an accepted pixel D at (col,row) with col≥1 and row≥1:
  - C = current row, col-1.
  - B = previous row, col.
  - A = previous row, col-1.
- Arithmetic, using 10-bit signed intermediates:
  - gx = ((B+D) − (A+C)) >>> 1
  - gy = ((C+D) − (A+B)) >>> 1
  - The shift is arithmetic, i.e. floor division. Results lie in [-255, 255] and never overflow 9 bits.
- `out_mag` = |gx| + |gy|, maximum 510.
- A pixel with col=0 or row=0 produces no output. Each frame produces exactly (IMG_WIDTH−1)(IMG_HEIGHT−1) outputs.
- `out_last` is set for the output generated by pixel (IMG_WIDTH−1, IMG_HEIGHT−1).
- There is no backpressure. The downstream stage accepts every `out_valid`.

## Timing
- Latency is exactly 3 cycles. Pixel D accepted at edge k produces `out_valid`=1 after edge k+3, with its results.
- The pipeline advances every cycle, with a valid bit carried per stage.
- Gaps in `in_valid` produce matching gaps in `out_valid`. Gaps do not change values or latency.
- Outputs update only with `out_valid`. When `out_valid`=0, the data outputs hold their last values.
- Back-to-back `in_valid` gives back-to-back results at 1 pixel per cycle.
- Reset values: `out_valid`=0, `out_last`=0, `out_x1`=0, `out_x2`=0, `out_mag`=0, `col`=0, `row`=0, all pipeline valid bits 0.
- Reset mid-frame:
  - All in-flight results are discarded, and no `out_valid` follows the reset.
  - The first pixel accepted after reset is (0,0).
  - Stale line-buffer data is never used, because row 0 produces no output.
- `in_sof` mid-frame: results already in the pipeline still emerge. The new frame's row 0 emits nothing, and `out_last` of the aborted frame never fires.
- `in_sof` without `in_valid` is ignored.

## Test plan
- **Flat image, small frame.** IMG_WIDTH=8, IMG_HEIGHT=4, all pixels 128, continuous `in_valid` → exactly 21 outputs, all `out_x1`=`out_x2`=`out_mag`=0. `out_last` only on the 21st output, which arrives 3 cycles after the final pixel.
- **Horizontal ramp.** Pixel = 32·col → every output has gx=32, gy=0, mag=32.
- **Vertical ramp.** Pixel = 64·row, clipped to ≤255 → gy=64, gx=0 on rows 1..3.
- **Edge and floor checks.**
  - Vertical step, 0 for col<4 and 255 for col≥4 → gx=255 at col=4, 0 elsewhere.
  - Mirrored step → gx=−255.
  - Neighbourhood A=1, B=C=D=0 → gx=−1, gy=−1, mag=2.
  - Neighbourhood B=1, A=C=D=0 → gx=0, gy=−1.
- **Bubbles.** Random `in_valid` gaps of 0–5 cycles on the ramp image → output sequence identical to the continuous run, each `out_valid` exactly 3 cycles after its pixel D.
- **Resynchronisation.**
  - `in_sof` at (3,2) → the next frame's outputs start at its pixel (1,1), with no `out_last` for the aborted frame.
  - `rst` pulse mid-line → `out_valid`=0 immediately, and the following frame yields 21 correct outputs.

Source files
------------

// File: rtl/gradient_calc_if.sv
// Pixel-in / gradient-out bundle for gradient_calc.
//   master : pixel source side (drives in_*, observes out_*)
//   slave  : gradient_calc side (observes in_*, drives out_*)
//   in_valid/in_sof/in_pixel : raster-order 8-bit pixel stream, in_sof marks (0,0)
//   out_valid/out_last       : result strobe and last-of-frame flag
//   out_x1/out_x2            : signed vertical / horizontal gradient
//   out_mag                  : |gx|+|gy|
interface gradient_calc_if;
   logic              in_valid;
   logic              in_sof;
   logic [7:0]        in_pixel;
   logic              out_valid;
   logic signed [8:0] out_x1;
   logic signed [8:0] out_x2;
   logic [8:0]        out_mag;
   logic              out_last;

   modport master (
      output in_valid, in_sof, in_pixel,
      input  out_valid, out_x1, out_x2, out_mag, out_last
   );

   modport slave (
      input  in_valid, in_sof, in_pixel,
      output out_valid, out_x1, out_x2, out_mag, out_last
   );
endinterface

// File: rtl/gradient_calc.sv
// 2x2 LSD image gradient over a raster pixel stream, 3-cycle latency, no backpressure.
//   clock, rst : rising-edge clock, asynchronous active-high reset
//   bus        : gradient_calc_if.slave (pixel stream in, gradient/magnitude out)
module gradient_calc #(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480
) (
   input  logic             clock,
   input  logic             rst,
   gradient_calc_if.slave   bus
);
   localparam int unsigned COL_W = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
   localparam int unsigned ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
   localparam int unsigned PIX_W = 8;
   localparam int unsigned GRD_W = 9;
   localparam int unsigned SUM_W = 10;

   // Previous-row line buffer; contents are never reset (row 0 never produces output).
   logic [PIX_W-1:0] line_mem [IMG_WIDTH];

   logic [COL_W-1:0] col_q, col_d, pos_col;
   logic [ROW_W-1:0] row_q, row_d, pos_row;
   logic [PIX_W-1:0] rd_b;
   logic [PIX_W-1:0] hist_b_q, hist_b_d, hist_c_q, hist_c_d;

   logic             s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
   logic [PIX_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_c_q, s1_c_d, s1_d_q, s1_d_d;

   logic signed [SUM_W-1:0] dx, dy;
   logic                    s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
   logic signed [GRD_W-1:0] s2_gx_q, s2_gx_d, s2_gy_q, s2_gy_d;

   logic                    s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
   logic signed [GRD_W-1:0] s3_gx_q, s3_gx_d, s3_gy_q, s3_gy_d;
   logic [GRD_W-1:0]        s3_ax_q, s3_ax_d, s3_ay_q, s3_ay_d;

   logic [SUM_W-1:0]        mag_sum;
   logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic signed [GRD_W-1:0] out_x1_q, out_x1_d, out_x2_q, out_x2_d;
   logic [GRD_W-1:0]        out_mag_q, out_mag_d;

   // Next-state and datapath for every pipeline stage.
   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      hist_b_d    = hist_b_q;
      hist_c_d    = hist_c_q;
      out_x1_d    = out_x1_q;
      out_x2_d    = out_x2_q;
      out_mag_d   = out_mag_q;

      // in_sof relocates the accepted pixel to (0,0) whatever the counters say.
      pos_col = bus.in_sof ? '0 : col_q;
      pos_row = bus.in_sof ? '0 : row_q;
      rd_b    = line_mem[pos_col];

      if (bus.in_valid) begin
         // B read now becomes A for the next pixel; this pixel becomes its C.
         hist_b_d = rd_b;
         hist_c_d = bus.in_pixel;
         if (pos_col == COL_W'(IMG_WIDTH - 1)) begin
            col_d = '0;
            row_d = (pos_row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : ROW_W'(pos_row + 1'b1);
         end else begin
            col_d = COL_W'(pos_col + 1'b1);
            row_d = pos_row;
         end
      end

      // Stage 1: capture the 2x2 neighbourhood.
      s1_valid_d = bus.in_valid && (pos_col != '0) && (pos_row != '0);
      s1_last_d  = (pos_col == COL_W'(IMG_WIDTH - 1)) && (pos_row == ROW_W'(IMG_HEIGHT - 1));
      s1_a_d     = hist_b_q;
      s1_b_d     = rd_b;
      s1_c_d     = hist_c_q;
      s1_d_d     = bus.in_pixel;

      // Stage 2: differences in 10 bits, arithmetic shift gives floor(/2).
      dx = SUM_W'(SUM_W'(s1_b_q) + SUM_W'(s1_d_q) - SUM_W'(s1_a_q) - SUM_W'(s1_c_q));
      dy = SUM_W'(SUM_W'(s1_c_q) + SUM_W'(s1_d_q) - SUM_W'(s1_a_q) - SUM_W'(s1_b_q));
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      s2_gx_d    = GRD_W'(dx >>> 1);
      s2_gy_d    = GRD_W'(dy >>> 1);

      // Stage 3: absolute values (|-255| still fits 9 bits).
      s3_valid_d = s2_valid_q;
      s3_last_d  = s2_last_q;
      s3_gx_d    = s2_gx_q;
      s3_gy_d    = s2_gy_q;
      s3_ax_d    = s2_gx_q[GRD_W-1] ? GRD_W'(-s2_gx_q) : GRD_W'(s2_gx_q);
      s3_ay_d    = s2_gy_q[GRD_W-1] ? GRD_W'(-s2_gy_q) : GRD_W'(s2_gy_q);

      // Output stage: data registers hold between valid results.
      mag_sum     = SUM_W'(s3_ax_q) + SUM_W'(s3_ay_q);
      out_valid_d = s3_valid_q;
      out_last_d  = s3_valid_q && s3_last_q;
      if (s3_valid_q) begin
         out_x1_d  = s3_gy_q;
         out_x2_d  = s3_gx_q;
         out_mag_d = mag_sum[SUM_W-1] ? {GRD_W{1'b1}} : mag_sum[GRD_W-1:0];
      end
   end

   // Line buffer write, no reset.
   always_ff @(posedge clock) begin
      if (bus.in_valid) line_mem[pos_col] <= bus.in_pixel;
   end

   // Pipeline and counter registers.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         col_q       <= '0;
         row_q       <= '0;
         hist_b_q    <= '0;
         hist_c_q    <= '0;
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_c_q      <= '0;
         s1_d_q      <= '0;
         s2_valid_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         s2_gx_q     <= '0;
         s2_gy_q     <= '0;
         s3_valid_q  <= 1'b0;
         s3_last_q   <= 1'b0;
         s3_gx_q     <= '0;
         s3_gy_q     <= '0;
         s3_ax_q     <= '0;
         s3_ay_q     <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_x1_q    <= '0;
         out_x2_q    <= '0;
         out_mag_q   <= '0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         hist_b_q    <= hist_b_d;
         hist_c_q    <= hist_c_d;
         s1_valid_q  <= s1_valid_d;
         s1_last_q   <= s1_last_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_c_q      <= s1_c_d;
         s1_d_q      <= s1_d_d;
         s2_valid_q  <= s2_valid_d;
         s2_last_q   <= s2_last_d;
         s2_gx_q     <= s2_gx_d;
         s2_gy_q     <= s2_gy_d;
         s3_valid_q  <= s3_valid_d;
         s3_last_q   <= s3_last_d;
         s3_gx_q     <= s3_gx_d;
         s3_gy_q     <= s3_gy_d;
         s3_ax_q     <= s3_ax_d;
         s3_ay_q     <= s3_ay_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_x1_q    <= out_x1_d;
         out_x2_q    <= out_x2_d;
         out_mag_q   <= out_mag_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_x1    = out_x1_q;
   assign bus.out_x2    = out_x2_q;
   assign bus.out_mag   = out_mag_q;
endmodule

// File: tb/tb_gradient_calc.sv
// Self-checking bench for gradient_calc on an 8x4 frame: vector table, image
// patterns, random bubbles, in_sof resync and mid-line reset against a frame model.
module tb_gradient_calc;
   localparam int W = 8;
   localparam int H = 4;

   logic clock = 1'b0;
   logic rst;
   always #5 clock = ~clock;

   gradient_calc_if bus();
   gradient_calc #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (.clock(clock), .rst(rst), .bus(bus));

   typedef struct {int gx; int gy; int mag; bit last; int due;} exp_t;
   typedef struct {int a; int b; int c; int d; int gx; int gy; int mag;} vec_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0, errors = 0;
   int   n_out = 0, n_last = 0;
   int   h_x1 = 0, h_x2 = 0, h_mag = 0;
   int   img [H][W];
   int   mcol = 0, mrow = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(string name, int act, int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic int fdiv2(int v);
      return (v >= 0) ? v / 2 : -((1 - v) / 2);
   endfunction

   function automatic int iabs(int v);
      return (v < 0) ? -v : v;
   endfunction

   // Frame model: store the pixel in a 2D image and derive the gradient from it.
   task automatic model_accept(int p, bit sof);
      exp_t e;
      int a, b, c;
      if (sof) begin mcol = 0; mrow = 0; end
      img[mrow][mcol] = p;
      if (mcol >= 1 && mrow >= 1) begin
         a = img[mrow-1][mcol-1];
         b = img[mrow-1][mcol];
         c = img[mrow][mcol-1];
         e.gx   = fdiv2((b + p) - (a + c));
         e.gy   = fdiv2((c + p) - (a + b));
         e.mag  = iabs(e.gx) + iabs(e.gy);
         if (e.mag > 511) e.mag = 511;
         e.last = (mcol == W-1) && (mrow == H-1);
         e.due  = cyc + 4;
         q.push_back(e);
      end
      mcol++;
      if (mcol == W) begin
         mcol = 0;
         mrow = (mrow == H-1) ? 0 : mrow + 1;
      end
   endtask

   // Output monitor, sampled on the falling edge.
   always @(negedge clock) begin : mon
      exp_t e;
      if (!rst) begin
         while (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            chk("missing_output_due", cyc, e.due);
         end
         if (bus.out_valid) begin
            n_out++;
            if (bus.out_last) n_last++;
            if (q.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               e = q.pop_front();
               chk("out_x2_gx", int'(bus.out_x2), e.gx);
               chk("out_x1_gy", int'(bus.out_x1), e.gy);
               chk("out_mag", int'(bus.out_mag), e.mag);
               chk("out_last", int'(bus.out_last), int'(e.last));
               chk("latency", cyc, e.due);
            end
            h_x1  = int'(bus.out_x1);
            h_x2  = int'(bus.out_x2);
            h_mag = int'(bus.out_mag);
         end else begin
            chk("hold_x1", int'(bus.out_x1), h_x1);
            chk("hold_x2", int'(bus.out_x2), h_x2);
            chk("hold_mag", int'(bus.out_mag), h_mag);
            chk("idle_last", int'(bus.out_last), 0);
         end
      end
   end

   task automatic drive_pix(int p, bit sof);
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_sof   = sof;
      bus.in_pixel = 8'(p);
      model_accept(p, sof);
   endtask

   task automatic drive_idle();
      @(negedge clock);
      bus.in_valid = 1'b0;
      bus.in_sof   = ($urandom_range(1, 0) == 1);  // ignored without in_valid
      bus.in_pixel = 8'($urandom_range(255, 0));
   endtask

   function automatic int pat(int kind, int c, int r);
      case (kind)
         0: return 128;
         1: return 32 * c;
         2: return (64 * r > 255) ? 255 : 64 * r;
         3: return (c >= 4) ? 255 : 0;
         4: return (c >= 4) ? 0 : 255;
         default: return int'($urandom_range(255, 0));
      endcase
   endfunction

   task automatic send_frame(int kind, int max_gap, bit sof, int npix);
      for (int i = 0; i < npix; i++) begin
         if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) drive_idle();
         drive_pix(pat(kind, i % W, i / W), sof && (i == 0));
      end
      drive_idle();
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
      chk("drain_pending", q.size(), 0);
      repeat (2) @(negedge clock);
   endtask

   task automatic reset_mid();
      @(negedge clock);
      bus.in_valid = 1'b0;
      #2 rst = 1'b1;
      q.delete();
      h_x1 = 0; h_x2 = 0; h_mag = 0;
      mcol = 0; mrow = 0;
      #1;
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_last", int'(bus.out_last), 0);
      chk("rst_out_mag", int'(bus.out_mag), 0);
      @(negedge clock);
      #2 rst = 1'b0;
   endtask

   vec_t tv[9];

   initial begin
      int o0, l0;
      tv[0] = '{1, 0, 0, 0, -1, -1, 2};
      tv[1] = '{0, 1, 0, 0, 0, -1, 1};
      tv[2] = '{0, 255, 0, 255, 255, 0, 255};
      tv[3] = '{255, 0, 255, 0, -255, 0, 255};
      tv[4] = '{0, 0, 255, 255, 0, 255, 255};
      tv[5] = '{255, 255, 255, 255, 0, 0, 0};
      tv[6] = '{10, 20, 30, 45, 12, 22, 34};
      tv[7] = '{3, 0, 0, 0, -2, -2, 4};
      tv[8] = '{255, 0, 0, 0, -128, -128, 256};

      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      bus.in_pixel = 8'd0;
      repeat (3) @(negedge clock);
      chk("reset_out_valid", int'(bus.out_valid), 0);
      chk("reset_out_last", int'(bus.out_last), 0);
      chk("reset_out_x1", int'(bus.out_x1), 0);
      chk("reset_out_x2", int'(bus.out_x2), 0);
      chk("reset_out_mag", int'(bus.out_mag), 0);
      rst = 1'b0;
      repeat (2) @(negedge clock);

      // Flat image: 21 zero results, out_last only on the 21st.
      o0 = n_out; l0 = n_last;
      send_frame(0, 0, 1'b1, W*H);
      drain();
      chk("flat_count", n_out - o0, 21);
      chk("flat_last_count", n_last - l0, 1);

      // Ramps and steps, continuous.
      for (int k = 1; k <= 4; k++) begin
         o0 = n_out;
         send_frame(k, 0, 1'b1, W*H);
         drain();
         chk("pattern_count", n_out - o0, 21);
      end

      // Neighbourhood table at pixel (1,1).
      foreach (tv[i]) begin
         drive_pix(tv[i].a, 1'b1);
         drive_pix(tv[i].b, 1'b0);
         for (int c = 2; c < W; c++) drive_pix(0, 1'b0);
         drive_pix(tv[i].c, 1'b0);
         o0 = n_out;
         drive_pix(tv[i].d, 1'b0);
         drive_idle();
         for (int t = 0; t < 8 && n_out == o0; t++) begin
            @(negedge clock); #1;
         end
         chk("vec_seen", n_out - o0, 1);
         chk("vec_gx", h_x2, tv[i].gx);
         chk("vec_gy", h_x1, tv[i].gy);
         chk("vec_mag", h_mag, tv[i].mag);
      end
      drain();

      // Horizontal ramp with random bubbles.
      o0 = n_out;
      send_frame(1, 5, 1'b1, W*H);
      drain();
      chk("bubble_count", n_out - o0, 21);

      // in_sof at (3,2): aborted frame never flags out_last.
      l0 = n_last;
      send_frame(5, 2, 1'b1, 2*W + 3);
      drain();
      chk("abort_no_last", n_last - l0, 0);
      o0 = n_out;
      send_frame(5, 2, 1'b1, W*H);
      drain();
      chk("resync_count", n_out - o0, 21);
      chk("resync_last", n_last - l0, 1);

      // Reset mid-line, then a frame without in_sof starts at (0,0).
      send_frame(5, 0, 1'b1, W + 3);
      reset_mid();
      o0 = n_out; l0 = n_last;
      send_frame(5, 1, 1'b0, W*H);
      drain();
      chk("post_rst_count", n_out - o0, 21);
      chk("post_rst_last", n_last - l0, 1);

      // Back-to-back random frames relying on counter wrap.
      o0 = n_out; l0 = n_last;
      send_frame(5, 3, 1'b1, 3*W*H);
      drain();
      chk("wrap_count", n_out - o0, 63);
      chk("wrap_last", n_last - l0, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
